// File: rtl/stall_mem_responder.sv
// Word-addressed memory model with independent instruction and data ports; each port
// answers a request after a fixed latency with a single-cycle ready pulse.
module stall_mem_responder #(
   parameter int    ADDR_WIDTH   = 32,
   parameter int    DATA_WIDTH   = 32,
   parameter int    DEPTH_WORDS  = 1024,
   parameter int    IMEM_LATENCY = 2,
   parameter int    DMEM_LATENCY = 3,
   parameter string INIT_FILE    = ""
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   pc,
   input  logic                    read_instr,
   output logic [DATA_WIDTH-1:0]   instr_i,
   output logic                    instr_ready_i,
   input  logic [ADDR_WIDTH-1:0]   dmem_addr,
   input  logic [DATA_WIDTH-1:0]   dmem_wdata,
   input  logic                    dmem_write_r,
   input  logic [DATA_WIDTH/8-1:0] dmem_wstrb,
   input  logic                    dmem_read,
   output logic [DATA_WIDTH-1:0]   dmem_rdata,
   output logic                    dmem_ready,
   output logic                    err_sticky
);
   localparam int STRB_W = DATA_WIDTH/8;
   localparam int IDX_W  = ADDR_WIDTH-2;
   localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH_WORDS);
   localparam logic [3:0] I_LOAD = 4'(IMEM_LATENCY-1);
   localparam logic [3:0] D_LOAD = 4'(DMEM_LATENCY-1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} port_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [STRB_W-1:0]     strb);
      logic [DATA_WIDTH-1:0] r;
      r = old_w;
      for (int b = 0; b < STRB_W; b++)
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return idx < DEPTH_IDX;
   endfunction

   function automatic logic [MEM_AW-1:0] mem_idx(input logic [IDX_W-1:0] idx);
      return idx[MEM_AW-1:0];
   endfunction

   logic addr_lsb_unused;
   assign addr_lsb_unused = ^{pc[1:0], dmem_addr[1:0]};

   // Instruction port
   port_state_t           i_state, i_state_nxt;
   logic [3:0]            i_cnt;
   logic [IDX_W-1:0]      i_idx, i_rd_idx;
   logic [DATA_WIDTH-1:0] i_rd_word;
   logic                  i_accept;

   // Data port
   port_state_t           d_state, d_state_nxt;
   logic [3:0]            d_cnt;
   logic [IDX_W-1:0]      d_idx, d_rd_idx;
   logic [DATA_WIDTH-1:0] d_wdata;
   logic [STRB_W-1:0]     d_wstrb;
   logic                  d_we, d_re, d_rd_is_read, d_accept, wr_commit;

   assign i_accept = (i_state == IDLE) && read_instr;
   assign i_rd_idx = (i_state == IDLE) ? pc[ADDR_WIDTH-1:2] : i_idx;
   assign instr_ready_i = (i_state == RESP);

   always_comb begin
      i_state_nxt = i_state;
      case (i_state)
         IDLE:    if (read_instr) i_state_nxt = (IMEM_LATENCY == 1) ? RESP : BUSY;
         BUSY:    if (i_cnt == 4'd1) i_state_nxt = RESP;
         RESP:    i_state_nxt = IDLE;
         default: i_state_nxt = IDLE;
      endcase
   end

   // A write committing on the same edge an instruction read samples is forwarded,
   // so a fetch entering RESP right after a store sees the stored value.
   always_comb begin
      i_rd_word = mem[mem_idx(i_rd_idx)];
      if (wr_commit && (d_idx == i_rd_idx)) i_rd_word = lane_merge(i_rd_word, d_wdata, d_wstrb);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_state <= IDLE;
         i_cnt   <= '0;
         instr_i <= '0;
      end else begin
         i_state <= i_state_nxt;
         if (i_accept) i_cnt <= I_LOAD;
         else if (i_state == BUSY) i_cnt <= i_cnt - 4'd1;
         if ((i_state_nxt == RESP) && (i_state != RESP))
            instr_i <= in_range(i_rd_idx) ? i_rd_word : '0;
      end
   end

   always_ff @(posedge clk)
      if (i_accept) i_idx <= pc[ADDR_WIDTH-1:2];

   assign d_accept     = (d_state == IDLE) && (dmem_read || dmem_write_r);
   assign d_rd_idx     = (d_state == IDLE) ? dmem_addr[ADDR_WIDTH-1:2] : d_idx;
   assign d_rd_is_read = (d_state == IDLE) ? (dmem_read && !dmem_write_r) : d_re;
   assign wr_commit    = (d_state == RESP) && d_we && in_range(d_idx);
   assign dmem_ready   = (d_state == RESP);

   always_comb begin
      d_state_nxt = d_state;
      case (d_state)
         IDLE:    if (dmem_read || dmem_write_r) d_state_nxt = (DMEM_LATENCY == 1) ? RESP : BUSY;
         BUSY:    if (d_cnt == 4'd1) d_state_nxt = RESP;
         RESP:    d_state_nxt = IDLE;
         default: d_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_state    <= IDLE;
         d_cnt      <= '0;
         dmem_rdata <= '0;
      end else begin
         d_state <= d_state_nxt;
         if (d_accept) d_cnt <= D_LOAD;
         else if (d_state == BUSY) d_cnt <= d_cnt - 4'd1;
         if ((d_state_nxt == RESP) && (d_state != RESP) && d_rd_is_read)
            dmem_rdata <= in_range(d_rd_idx) ? mem[mem_idx(d_rd_idx)] : '0;
      end
   end

   // Simultaneous read+write keeps the write and drops the read.
   always_ff @(posedge clk) begin
      if (d_accept) begin
         d_idx   <= dmem_addr[ADDR_WIDTH-1:2];
         d_wdata <= dmem_wdata;
         d_wstrb <= dmem_wstrb;
         d_we    <= dmem_write_r;
         d_re    <= dmem_read && !dmem_write_r;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_sticky <= 1'b0;
      else if ((i_accept && !in_range(pc[ADDR_WIDTH-1:2])) ||
               (d_accept && (!in_range(dmem_addr[ADDR_WIDTH-1:2]) || (dmem_read && dmem_write_r))))
         err_sticky <= 1'b1;
   end

   always_ff @(posedge clk)
      if (wr_commit) mem[mem_idx(d_idx)] <= lane_merge(mem[mem_idx(d_idx)], d_wdata, d_wstrb);

endmodule
